router_cc: RTL and testbench

- Five-port, credit-based, wormhole-switched NoC router for a 2D mesh, with XY routing.
- Sits at one mesh node. It connects the local core (LOCAL) to the four neighbour routers (EAST, WEST, NORTH, SOUTH).
- Each input port has its own FIFO. A single round-robin switch controller sets up input-to-output connections and tears each one down after the packet's last flit.

---
 rtl/router_cc_if.sv | 26 ++
 rtl/router_cc.sv | 225 ++++++++++++++++++++++
 tb/tb_router_cc.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_cc_if.sv
// router_cc_if: five-port flit/credit link bundle between the router and its neighbours.
// slave = router side, master = neighbour/core side.
interface router_cc_if #(
   parameter int unsigned FLIT_WIDTH = 16
);
   localparam int unsigned NPORT = 5;

   logic [NPORT-1:0]            clock_rx;
   logic [NPORT-1:0]            rx;
   logic [NPORT*FLIT_WIDTH-1:0] data_in;
   logic [NPORT-1:0]            credit_o;
   logic [NPORT-1:0]            clock_tx;
   logic [NPORT-1:0]            tx;
   logic [NPORT*FLIT_WIDTH-1:0] data_out;
   logic [NPORT-1:0]            credit_i;

   modport slave (
      input  clock_rx, rx, data_in, credit_i,
      output credit_o, clock_tx, tx, data_out
   );

   modport master (
      output clock_rx, rx, data_in, credit_i,
      input  credit_o, clock_tx, tx, data_out
   );
endinterface

// File: rtl/router_cc.sv
// router_cc: 5-port credit-based wormhole NoC router with XY routing.
// Ports 0..4 = EAST, WEST, NORTH, SOUTH, LOCAL. One FIFO per input, one
// round-robin switch controller. Optional macro ROUTERCC_PKT_COUNT_EN adds
// pkt_count, a count of packets whose connection has released.
module router_cc #(
   parameter logic [7:0]  ADDRESS      = 8'h00,
   parameter int unsigned FLIT_WIDTH   = 16,
   parameter int unsigned BUFFER_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   router_cc_if.slave  link
`ifdef ROUTERCC_PKT_COUNT_EN
   ,
   output logic [31:0] pkt_count
`endif
);
   localparam int unsigned NPORT = 5;
   localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned IDX_W = 3;
   localparam logic [IDX_W-1:0] EAST  = 3'd0;
   localparam logic [IDX_W-1:0] WEST  = 3'd1;
   localparam logic [IDX_W-1:0] NORTH = 3'd2;
   localparam logic [IDX_W-1:0] SOUTH = 3'd3;
   localparam logic [IDX_W-1:0] LOCAL = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE} state_t;

   logic [FLIT_WIDTH-1:0] mem [NPORT][BUFFER_DEPTH];
   logic [PTR_W-1:0]      rd_ptr [NPORT];
   logic [PTR_W-1:0]      wr_ptr [NPORT];
   logic [OCC_W-1:0]      occ [NPORT];
   logic [FLIT_WIDTH-1:0] head [NPORT];
   logic [NPORT-1:0]      full, empty, push, pop, req, rel;

   logic [NPORT-1:0]      in_busy, out_busy, sizing;
   logic [IDX_W-1:0]      in_out [NPORT];
   logic [IDX_W-1:0]      out_src [NPORT];
   logic [FLIT_WIDTH-1:0] cnt [NPORT];

   state_t                state, state_nx;
   logic [IDX_W-1:0]      sel, rr, grant_c, route_c, cand_c;
   logic                  grant_vld_c, connect_c, advance_c;
   logic [NPORT-1:0]      tx_c;
   logic [NPORT*FLIT_WIDTH-1:0] data_c;

   // Link clocks from neighbours are not used; everything runs on clock.
   logic unused_clock_rx;
   assign unused_clock_rx = &{1'b0, link.clock_rx};

   // XY route: resolve X first, then Y, else deliver locally.
   function automatic logic [IDX_W-1:0] xy_route(input logic [7:0] dst);
      logic [IDX_W-1:0] r;
      if (dst[7:4] > ADDRESS[7:4])      r = EAST;
      else if (dst[7:4] < ADDRESS[7:4]) r = WEST;
      else if (dst[3:0] > ADDRESS[3:0]) r = NORTH;
      else if (dst[3:0] < ADDRESS[3:0]) r = SOUTH;
      else                              r = LOCAL;
      return r;
   endfunction

   // FIFO status and arbitration requests (unconnected input with a header at its head).
   always_comb begin
      full  = '0;
      empty = '0;
      req   = '0;
      for (int p = 0; p < NPORT; p++) begin
         full[p]  = (occ[p] == OCC_W'(BUFFER_DEPTH));
         empty[p] = (occ[p] == '0);
         head[p]  = mem[p][rd_ptr[p]];
         req[p]   = ~empty[p] & ~in_busy[p];
      end
   end

   // Pop on forwarded flit; flag the final flit of a packet for release.
   always_comb begin
      pop = '0;
      rel = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (in_busy[i] && !empty[i] && link.credit_i[in_out[i]]) begin
            pop[i] = 1'b1;
            if (sizing[i]) rel[i] = (cnt[i] == FLIT_WIDTH'(1)) && (head[i] == '0);
            else           rel[i] = (cnt[i] == FLIT_WIDTH'(1));
         end
      end
   end

   // Push accepted when space exists, or when a pop frees a slot the same cycle.
   always_comb begin
      push = '0;
      for (int p = 0; p < NPORT; p++) push[p] = link.rx[p] & (~full[p] | pop[p]);
   end

   // Crossbar: connected outputs show the head of their source FIFO.
   always_comb begin
      tx_c   = '0;
      data_c = '0;
      for (int o = 0; o < NPORT; o++) begin
         if (out_busy[o]) begin
            tx_c[o] = ~empty[out_src[o]];
            data_c[o*FLIT_WIDTH +: FLIT_WIDTH] = head[out_src[o]];
         end
      end
   end

   assign link.tx       = tx_c;
   assign link.data_out = data_c;
   assign link.credit_o = ~full;
   assign link.clock_tx = {NPORT{clock}};

   // Switch controller state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Switch controller next state: IDLE -> ARB (round robin) -> ROUTE (connect if free).
   always_comb begin
      state_nx    = state;
      grant_c     = sel;
      grant_vld_c = 1'b0;
      connect_c   = 1'b0;
      advance_c   = 1'b0;
      cand_c      = '0;
      route_c     = xy_route(head[sel][7:0]);
      unique case (state)
         S_IDLE: if (|req) state_nx = S_ARB;
         S_ARB: begin
            // Scan downward so the lowest offset after rr wins.
            for (int k = NPORT; k >= 1; k--) begin
               cand_c = IDX_W'((32'(rr) + 32'(k)) % NPORT);
               if (req[cand_c]) begin
                  grant_c     = cand_c;
                  grant_vld_c = 1'b1;
               end
            end
            state_nx = grant_vld_c ? S_ROUTE : S_IDLE;
         end
         S_ROUTE: begin
            advance_c = 1'b1;
            connect_c = ~out_busy[route_c];
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Connection table, rr pointer and per-connection flit counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sel      <= '0;
         rr       <= EAST;
         in_busy  <= '0;
         out_busy <= '0;
         sizing   <= '0;
         for (int p = 0; p < NPORT; p++) begin
            in_out[p]  <= '0;
            out_src[p] <= '0;
            cnt[p]     <= '0;
         end
      end else begin
         if (grant_vld_c) sel <= grant_c;
         if (advance_c)   rr  <= sel;
         for (int i = 0; i < NPORT; i++) begin
            if (pop[i]) begin
               if (rel[i]) begin
                  in_busy[i]           <= 1'b0;
                  out_busy[in_out[i]]  <= 1'b0;
               end else if (sizing[i] && cnt[i] == FLIT_WIDTH'(1)) begin
                  cnt[i]    <= head[i];
                  sizing[i] <= 1'b0;
               end else begin
                  cnt[i] <= cnt[i] - FLIT_WIDTH'(1);
               end
            end
         end
         if (connect_c) begin
            in_busy[sel]      <= 1'b1;
            in_out[sel]       <= route_c;
            out_busy[route_c] <= 1'b1;
            out_src[route_c]  <= sel;
            cnt[sel]          <= FLIT_WIDTH'(2);
            sizing[sel]       <= 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at BUFFER_DEPTH.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NPORT; p++) begin
            rd_ptr[p] <= '0;
            wr_ptr[p] <= '0;
            occ[p]    <= '0;
         end
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
            if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
            case ({push[p], pop[p]})
               2'b10:   occ[p] <= occ[p] + OCC_W'(1);
               2'b01:   occ[p] <= occ[p] - OCC_W'(1);
               default: occ[p] <= occ[p];
            endcase
         end
      end
   end

   // FIFO storage (no reset needed; occupancy guards reads).
   always_ff @(posedge clock) begin
      for (int p = 0; p < NPORT; p++) begin
         if (push[p]) mem[p][wr_ptr[p]] <= link.data_in[p*FLIT_WIDTH +: FLIT_WIDTH];
      end
   end

`ifdef ROUTERCC_PKT_COUNT_EN
   // Released-packet counter; several connections may release in one cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)    pkt_count <= '0;
      else if (|rel) pkt_count <= pkt_count + 32'($countones(rel));
   end
`endif

endmodule

// File: tb/tb_router_cc.sv
// tb_router_cc: scoreboard bench for router_cc (ADDRESS=0x11).
module tb_router_cc;
   localparam int unsigned FW = 16;
   localparam logic [7:0]  ADDR = 8'h11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   router_cc_if #(.FLIT_WIDTH(FW)) bus ();
`ifdef ROUTERCC_PKT_COUNT_EN
   logic [31:0] pkt_count;
`endif

   router_cc #(.ADDRESS(ADDR), .FLIT_WIDTH(FW), .BUFFER_DEPTH(4)) dut (
      .clock (clk),
      .reset (rst_n),
      .link  (bus)
`ifdef ROUTERCC_PKT_COUNT_EN
      ,
      .pkt_count (pkt_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [FW-1:0] exp_q [5][$];
   int  rx_cnt [5] = '{0, 0, 0, 0, 0};
   bit  abort = 1'b0;
   logic [FW-1:0] mon_got, mon_exp;

   // Bench routing model.
   function automatic int route_of(input logic [7:0] d);
      int dx, dy, cx, cy;
      dx = int'(d[7:4]); dy = int'(d[3:0]);
      cx = int'(ADDR[7:4]); cy = int'(ADDR[3:0]);
      if (dx > cx) return 0;
      if (dx < cx) return 1;
      if (dy > cy) return 2;
      if (dy < cy) return 3;
      return 4;
   endfunction

   function automatic logic [FW-1:0] flit_of(input logic [7:0] dst, input int n,
                                             input logic [FW-1:0] seed, input int k);
      if (k == 0) return {8'h00, dst};
      if (k == 1) return FW'(n);
      return seed + FW'((k - 2) * 32'h1111);
   endfunction

   function automatic int pending();
      int s = 0;
      for (int o = 0; o < 5; o++) s += exp_q[o].size();
      return s;
   endfunction

   // Monitor: every accepted output flit must match the next expected flit on that port.
   always @(negedge clk) begin
      for (int o = 0; o < 5; o++) begin
         if (bus.tx[o] && bus.credit_i[o]) begin
            mon_got = bus.data_out[o*FW +: FW];
            n_checks++;
            rx_cnt[o]++;
            if (exp_q[o].size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_flit port %0d: got %h, required no flit", o, mon_got);
            end else begin
               mon_exp = exp_q[o].pop_front();
               if (mon_got !== mon_exp) begin
                  n_fail++;
                  $display("FAIL flit_data port %0d: got %h, required %h", o, mon_got, mon_exp);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_pkt(input logic [7:0] dst, input int n, input logic [FW-1:0] seed);
      for (int k = 0; k < n + 2; k++) exp_q[route_of(dst)].push_back(flit_of(dst, n, seed, k));
   endtask

   // Credit-honouring sender; called at posedge+1.
   task automatic drive_pkt(input int p, input logic [7:0] dst, input int n, input logic [FW-1:0] seed);
      int k = 0;
      int g = 0;
      while (k < n + 2 && !abort && g < 2000) begin
         if (bus.credit_o[p]) begin
            bus.rx[p] = 1'b1;
            bus.data_in[p*FW +: FW] = flit_of(dst, n, seed, k);
            k++;
         end else begin
            bus.rx[p] = 1'b0;
         end
         tick(1);
         g++;
      end
      bus.rx[p] = 1'b0;
      if (g >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout port %0d: sent %0d, required %0d", p, k, n + 2);
      end
   endtask

   task automatic wait_drain(input string name);
      int g = 0;
      while (pending() != 0 && g < 500) begin
         tick(1);
         g++;
      end
      n_checks++;
      if (pending() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d flits outstanding, required 0", name, pending());
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.rx = '0;
      for (int o = 0; o < 5; o++) exp_q[o].delete();
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      bus.clock_rx = '0;
      bus.rx       = '0;
      bus.data_in  = '0;
      bus.credit_i = '1;
      rst_n        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.credit_o !== 5'b11111) begin n_fail++; $display("FAIL reset_credit: got %b, required 11111", bus.credit_o); end
      n_checks++;
      if (bus.tx !== 5'b00000) begin n_fail++; $display("FAIL reset_tx: got %b, required 00000", bus.tx); end
      n_checks++;
      if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", bus.data_out); end
`ifdef ROUTERCC_PKT_COUNT_EN
      n_checks++;
      if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d, required 0", pkt_count); end
`endif
      rst_n = 1'b1;
      tick(1);
      n_checks++;
      if (bus.credit_o !== 5'b11111) begin n_fail++; $display("FAIL post_reset_credit: got %b, required 11111", bus.credit_o); end
      n_checks++;
      if (bus.tx !== 5'b00000) begin n_fail++; $display("FAIL post_reset_tx: got %b, required 00000", bus.tx); end
   endtask

   task automatic test_local_east();
      int lat = 0;
      expect_pkt(8'h21, 2, 16'hAAAA);
      fork
         drive_pkt(4, 8'h21, 2, 16'hAAAA);
         begin
            @(posedge clk);
            for (int c = 1; c <= 8; c++) begin
               @(posedge clk);
               #1;
               if (lat == 0 && bus.tx[0]) lat = c;
            end
         end
      join
      n_checks++;
      if (lat != 3) begin n_fail++; $display("FAIL header_latency: got %0d cycles, required 3", lat); end
      wait_drain("local_east");
`ifdef ROUTERCC_PKT_COUNT_EN
      n_checks++;
      if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL pkt_count_one: got %0d, required 1", pkt_count); end
`endif
   endtask

   task automatic test_routes();
      logic [7:0] dsts [4] = '{8'h01, 8'h12, 8'h10, 8'h11};
      int         port [4] = '{1, 2, 3, 4};
      int base;
      for (int r = 0; r < 4; r++) begin
         base = rx_cnt[port[r]];
         expect_pkt(dsts[r], 0, 16'h0);
         drive_pkt(4, dsts[r], 0, 16'h0);
         wait_drain("route");
         n_checks++;
         if (rx_cnt[port[r]] - base != 2) begin
            n_fail++;
            $display("FAIL route_port dst %h: port %0d got %0d flits, required 2", dsts[r], port[r], rx_cnt[port[r]] - base);
         end
      end
   endtask

   task automatic test_backpressure();
      int base = rx_cnt[0];
      bus.credit_i[0] = 1'b0;
      expect_pkt(8'h21, 10, 16'h1000);
      fork
         drive_pkt(4, 8'h21, 10, 16'h1000);
         begin
            tick(10);
            n_checks++;
            if (bus.credit_o[4] !== 1'b0) begin n_fail++; $display("FAIL bp_credit_full: got %b, required 0", bus.credit_o[4]); end
            n_checks++;
            if (rx_cnt[0] != base) begin n_fail++; $display("FAIL bp_stalled: got %0d flits, required 0", rx_cnt[0] - base); end
            bus.credit_i[0] = 1'b1;
         end
      join
      wait_drain("backpressure");
      n_checks++;
      if (rx_cnt[0] - base != 12) begin n_fail++; $display("FAIL bp_count: got %0d flits, required 12", rx_cnt[0] - base); end
   endtask

   task automatic test_contention();
      do_reset();
      // rr starts at EAST: NORTH is scanned before SOUTH.
      expect_pkt(8'h21, 3, 16'h2000);
      expect_pkt(8'h21, 3, 16'h3000);
      fork
         drive_pkt(2, 8'h21, 3, 16'h2000);
         drive_pkt(3, 8'h21, 3, 16'h3000);
      join
      wait_drain("contention1");
      // A lone NORTH packet leaves rr at NORTH, so SOUTH wins next.
      expect_pkt(8'h01, 1, 16'h4000);
      drive_pkt(2, 8'h01, 1, 16'h4000);
      wait_drain("north_west");
      expect_pkt(8'h21, 2, 16'h6000);
      expect_pkt(8'h21, 2, 16'h5000);
      fork
         drive_pkt(2, 8'h21, 2, 16'h5000);
         drive_pkt(3, 8'h21, 2, 16'h6000);
      join
      wait_drain("contention2");
   endtask

   task automatic test_reset_mid();
      int base = rx_cnt[0];
      int g = 0;
      expect_pkt(8'h21, 4, 16'h7000);
      fork
         drive_pkt(4, 8'h21, 4, 16'h7000);
         begin
            while (rx_cnt[0] - base < 2 && g < 100) begin
               @(negedge clk);
               #1;
               g++;
            end
            @(posedge clk);
            #2;
            abort = 1'b1;
            rst_n = 1'b0;
            #1;
            for (int o = 0; o < 5; o++) exp_q[o].delete();
            n_checks++;
            if (g >= 100) begin n_fail++; $display("FAIL mid_progress: got %0d flits, required 2", rx_cnt[0] - base); end
            n_checks++;
            if (bus.tx !== 5'b00000) begin n_fail++; $display("FAIL mid_reset_tx: got %b, required 00000", bus.tx); end
            n_checks++;
            if (bus.data_out !== '0) begin n_fail++; $display("FAIL mid_reset_data: got %h, required 0", bus.data_out); end
            n_checks++;
            if (bus.credit_o !== 5'b11111) begin n_fail++; $display("FAIL mid_reset_credit: got %b, required 11111", bus.credit_o); end
            tick(2);
            rst_n = 1'b1;
         end
      join
      abort = 1'b0;
      tick(1);
`ifdef ROUTERCC_PKT_COUNT_EN
      n_checks++;
      if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL mid_pkt_count: got %0d, required 0", pkt_count); end
`endif
      base = rx_cnt[2];
      expect_pkt(8'h12, 1, 16'h8000);
      drive_pkt(4, 8'h12, 1, 16'h8000);
      wait_drain("after_reset");
      n_checks++;
      if (rx_cnt[2] - base != 3) begin n_fail++; $display("FAIL after_reset_count: got %0d flits, required 3", rx_cnt[2] - base); end
`ifdef ROUTERCC_PKT_COUNT_EN
      n_checks++;
      if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL after_reset_pkt_count: got %0d, required 1", pkt_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_local_east();
      test_routes();
      test_backpressure();
      test_contention();
      test_reset_mid();
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
